// File: rtl/fp_add_pkg.sv
// Shared binary32 field widths and operand view for the fp_add issue path.
package fp_add_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RM_W   = 3;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } fp32_t;

endpackage

// File: rtl/fp_add_result_fifo.sv
// Small result buffer between the adder output register and the result stream.
module fp_add_result_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WORD_W-1:0]          push_data,
    input  logic                       pop,
    output logic [WORD_W-1:0]          head,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Explicit wrap so non-power-of-two depths stay inside the storage.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fp_add_issue_ctrl.sv
// Issue/retire control around an external 1-cycle binary32 adder: operand
// unpacking, adder hold, result buffering and op/result counters.
module fp_add_issue_ctrl
    import fp_add_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic [RM_W-1:0]   in_rm,
    output logic              a_sign,
    output logic [EXP_W-1:0]  a_exp,
    output logic [MAN_W-1:0]  a_man,
    output logic              b_sign,
    output logic [EXP_W-1:0]  b_exp,
    output logic [MAN_W-1:0]  b_man,
    output logic [RM_W-1:0]   rm,
    output logic              astall,
    input  logic [WORD_W-1:0] x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_x,
    output logic [CNT_W-1:0]  cnt_in,
    output logic [CNT_W-1:0]  cnt_out
);

    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    fp32_t             op_a;
    fp32_t             op_b;
    logic              v1;
    logic              pop;
    logic              push;
    logic              accept;
    logic              full;
    logic [FCNT_W-1:0] count;

    always_comb begin
        op_a   = in_a;
        op_b   = in_b;
        a_sign = op_a.sign;
        a_exp  = op_a.exponent;
        a_man  = op_a.mantissa;
        b_sign = op_b.sign;
        b_exp  = op_b.exponent;
        b_man  = op_b.mantissa;
        rm     = in_rm;
    end

    // A pop in the same cycle frees the slot the adder result needs.
    always_comb begin
        pop       = out_valid & out_ready;
        astall    = v1 & full & ~pop;
        in_ready  = ~astall;
        accept    = in_valid & in_ready;
        push      = v1 & ~astall;
        out_valid = (count != '0);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            v1      <= 1'b0;
            cnt_in  <= '0;
            cnt_out <= '0;
        end else begin
            if (!astall) v1 <= accept;
            if (accept)  cnt_in  <= cnt_in + 1'b1;
            if (pop)     cnt_out <= cnt_out + 1'b1;
        end
    end

    fp_add_result_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_result_fifo (
        .clk       (aclk),
        .rst       (areset),
        .push      (push),
        .push_data (x),
        .pop       (pop),
        .head      (out_x),
        .full      (full),
        .count     (count)
    );

endmodule

// File: doc/fp_add_issue_ctrl.md
FP_ADD_ISSUE_CTRL -- requirements
Module: fp_add_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output result FIFO depth (legal values 2..4).
REQ-002 SHALL have port aclk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  operand pair valid.
REQ-005 SHALL have port in_ready  out  1  operand pair accepted this cycle when in_valid&in_ready.
REQ-006 SHALL have ports in_a, in_b  in  32  IEEE-754 binary32 operands.
REQ-007 SHALL have port in_rm  in  3  rounding mode, passed through unchanged.
REQ-008 SHALL have ports a_sign/b_sign out 1, a_exp/b_exp out 8, a_man/b_man out 23, rm out 3  unpacked operands to the 1-stage adder.
REQ-009 SHALL have port astall  out  1  adder pipe hold; adder output register loads only when astall=0.
REQ-010 SHALL have port x  in  32  adder registered result.
REQ-011 SHALL have ports out_valid out 1, out_ready in 1, out_x out 32  result stream.
REQ-012 SHALL have ports cnt_in, cnt_out  out  16  accepted-op and delivered-result counters.

Function
REQ-013 SHALL drive a_sign=in_a[31], a_exp=in_a[30:23], a_man=in_a[22:0] (likewise b_*), rm=in_rm, combinationally.
REQ-014 SHALL hold a valid bit v1 tracking the adder's output register; v1 loads in_valid&in_ready when astall=0, else holds.
REQ-015 SHALL treat x as valid exactly in cycles where v1=1 (adder latency 1 cycle after acceptance).
REQ-016 SHALL compute pop = out_valid & out_ready; full = (count==DEPTH).
REQ-017 SHALL drive astall = v1 & full & ~pop (pop frees a slot in the same cycle).
REQ-018 SHALL drive in_ready = ~astall; in_ready SHALL NOT depend on in_valid.
REQ-019 SHALL push x into the FIFO when v1 & ~astall; simultaneous push and pop SHALL leave count unchanged.
REQ-020 SHALL drive out_valid = (count!=0) and out_x = FIFO head; FIFO is first-in first-out with wrap-around pointers of width clog2(DEPTH).
REQ-021 SHALL sustain one accepted op and one delivered result per cycle while out_ready=1 (no bubbles).
REQ-022 SHALL preserve result order and never drop or duplicate a result under any out_ready pattern.
REQ-023 SHALL increment cnt_in on each acceptance and cnt_out on each pop, both wrapping 0xFFFF->0x0000.
REQ-024 SHALL keep out_x stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL, on areset=1 at a clock edge, clear v1, count, read/write pointers, cnt_in, cnt_out; out_valid=0, astall=0, in_ready=1 the following cycle.
REQ-026 SHALL discard any in-flight op and FIFO contents on reset mid-operation; FIFO data storage need not be reset.
REQ-027 SHALL ignore in_valid and out_ready in cycles where areset=1 (no counter or pointer change).

Structure
REQ-028 SHALL place binary32 field widths (EXP_W=8, MAN_W=23, WORD_W=32) and the rm width in a shared package fp_add_pkg.
REQ-029 SHALL implement the result buffer as sub-module fp_add_result_fifo (DEPTH, WORD_W parameters, push/pop/full/count ports).
REQ-030 SHALL NOT instantiate the adder; the adder connects at the parent level via the ports of REQ-008..REQ-010.

Verification
REQ-031 Bench SHALL couple the block to a 1-cycle registered adder model honouring astall.
REQ-032 Single op: in_a=0x3F800000, in_b=0x40000000, rm=0, out_ready=1 -> out_valid=1 two cycles after acceptance with out_x=0x40400000, cnt_in=cnt_out=1.
REQ-033 Streaming: 100 back-to-back ops, out_ready=1 -> in_ready never low, 100 results in order, cnt_out=100.
REQ-034 Backpressure: out_ready=0 with continuous in_valid -> exactly DEPTH+1 ops accepted, then astall=1 and in_ready=0; raising out_ready drains all in order with no loss.
REQ-035 Pop-through at full: count==DEPTH, v1=1, out_ready=1 -> astall=0, count stays DEPTH, next op accepted same cycle.
REQ-036 Reset mid-stream: assert areset with count==2, v1=1 -> next cycle out_valid=0, cnt_in=cnt_out=0, in_ready=1; no stale result emerges afterwards.
REQ-037 Counter wrap: preload 0xFFFF ops -> cnt_in wraps to 0x0000 on the next acceptance.
